// File: rtl/exec_cond_stage.sv
// D->E control register, NZCV flags and condition gating; controls 1 cycle after D, StallE holds E and flags, FlushE loads a bubble.
// Optional perf counters (ExecCnt/SquashCnt) are built only when EXEC_PERF_CNT_EN is defined.
module exec_cond_stage #(
    parameter logic [3:0] FLAGS_INIT = 4'b0000,
    parameter int         CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic [3:0]       CondD,
    input  logic             PCSD,
    input  logic             RegWD,
    input  logic             MemWD,
    input  logic             MemtoRegD,
    input  logic             ALUSrcD,
    input  logic             NoWriteD,
    input  logic [1:0]       FlagWD,
    input  logic [1:0]       ALUControlD,
    input  logic [3:0]       ALUFlagsE,
    output logic             ValidE,
    output logic             CondExE,
    output logic             PCSrcE,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             MemtoRegE,
    output logic             ALUSrcE,
    output logic [1:0]       ALUControlE,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SquashCnt
);

    typedef struct packed {
        logic       valid;
        logic [3:0] cond;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       memtoreg;
        logic       alusrc;
        logic       nowrite;
        logic [1:0] flagw;
        logic [1:0] aluctl;
    } e_ctrl_t;

    // A bubble carries AL so it can never look like a reserved-condition instruction.
    localparam e_ctrl_t BUBBLE = '{valid: 1'b0, cond: 4'hE, pcs: 1'b0, regw: 1'b0,
                                   memw: 1'b0, memtoreg: 1'b0, alusrc: 1'b0,
                                   nowrite: 1'b0, flagw: 2'b00, aluctl: 2'b00};

    e_ctrl_t    e_d, e_q;
    logic [3:0] flags_d, flags_q;
    logic       cond_pass;
    logic       n_f, z_f, c_f, v_f;

    always_comb begin
        e_d = e_q;
        if (FlushE) begin
            e_d = BUBBLE;
        end else if (!StallE) begin
            e_d = '{valid: 1'b1, cond: CondD, pcs: PCSD, regw: RegWD, memw: MemWD,
                    memtoreg: MemtoRegD, alusrc: ALUSrcD, nowrite: NoWriteD,
                    flagw: FlagWD, aluctl: ALUControlD};
        end
    end

    assign {n_f, z_f, c_f, v_f} = flags_q;

    // Evaluated on committed flags only; ALU flags of the E instruction land at its exit edge.
    always_comb begin
        cond_pass = 1'b0;
        case (e_q.cond)
            4'h0: cond_pass = z_f;
            4'h1: cond_pass = !z_f;
            4'h2: cond_pass = c_f;
            4'h3: cond_pass = !c_f;
            4'h4: cond_pass = n_f;
            4'h5: cond_pass = !n_f;
            4'h6: cond_pass = v_f;
            4'h7: cond_pass = !v_f;
            4'h8: cond_pass = c_f && !z_f;
            4'h9: cond_pass = !c_f || z_f;
            4'hA: cond_pass = (n_f == v_f);
            4'hB: cond_pass = (n_f != v_f);
            4'hC: cond_pass = !z_f && (n_f == v_f);
            4'hD: cond_pass = z_f || (n_f != v_f);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign CondExE     = e_q.valid && cond_pass;
    assign ValidE      = e_q.valid;
    assign PCSrcE      = e_q.pcs && CondExE;
    assign RegWriteE   = e_q.regw && CondExE && !e_q.nowrite;
    assign MemWriteE   = e_q.memw && CondExE;
    assign MemtoRegE   = e_q.memtoreg;
    assign ALUSrcE     = e_q.alusrc;
    assign ALUControlE = e_q.aluctl;
    assign Flags       = flags_q;

    always_comb begin
        flags_d = flags_q;
        if (!StallE && CondExE) begin
            if (e_q.flagw[1]) flags_d[3:2] = ALUFlagsE[3:2];
            if (e_q.flagw[0]) flags_d[1:0] = ALUFlagsE[1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q     <= BUBBLE;
            flags_q <= FLAGS_INIT;
        end else begin
            e_q     <= e_d;
            flags_q <= flags_d;
        end
    end

`ifdef EXEC_PERF_CNT_EN
    logic [CNT_W-1:0] exec_cnt_d, exec_cnt_q;
    logic [CNT_W-1:0] squash_cnt_d, squash_cnt_q;

    always_comb begin
        exec_cnt_d   = exec_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (e_q.valid && !StallE) begin
            if (CondExE) begin
                if (exec_cnt_q != '1) exec_cnt_d = exec_cnt_q + CNT_W'(1);
            end else begin
                if (squash_cnt_q != '1) squash_cnt_d = squash_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_cnt_q   <= '0;
            squash_cnt_q <= '0;
        end else begin
            exec_cnt_q   <= exec_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign ExecCnt   = exec_cnt_q;
    assign SquashCnt = squash_cnt_q;
`else
    assign ExecCnt   = '0;
    assign SquashCnt = '0;
`endif

endmodule

// File: tb/tb_exec_cond_stage.sv
// Directed bench for exec_cond_stage: flags, condition codes, stall/flush, reset and perf counters.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: StallE/FlushE driven directly by the stimulus sequence.
module tb_exec_cond_stage;

    logic       clk;
    logic       reset;
    logic       StallE, FlushE;
    logic [3:0] CondD;
    logic       PCSD, RegWD, MemWD, MemtoRegD, ALUSrcD, NoWriteD;
    logic [1:0] FlagWD, ALUControlD;
    logic [3:0] ALUFlagsE;
    logic       ValidE, CondExE, PCSrcE, RegWriteE, MemWriteE, MemtoRegE, ALUSrcE;
    logic [1:0] ALUControlE;
    logic [3:0] Flags;
    logic [3:0] ExecCnt, SquashCnt;

    int checks   = 0;
    int failures = 0;

    exec_cond_stage #(.FLAGS_INIT(4'b0100), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
        .CondD(CondD), .PCSD(PCSD), .RegWD(RegWD), .MemWD(MemWD),
        .MemtoRegD(MemtoRegD), .ALUSrcD(ALUSrcD), .NoWriteD(NoWriteD),
        .FlagWD(FlagWD), .ALUControlD(ALUControlD), .ALUFlagsE(ALUFlagsE),
        .ValidE(ValidE), .CondExE(CondExE), .PCSrcE(PCSrcE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
        .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .Flags(Flags),
        .ExecCnt(ExecCnt), .SquashCnt(SquashCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input bit ok);
        checks++;
        if (!ok) begin
            failures++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic pcs, input logic regw,
                         input logic memw, input logic nowr, input logic [1:0] fw);
        CondD    = c;
        PCSD     = pcs;
        RegWD    = regw;
        MemWD    = memw;
        NoWriteD = nowr;
        FlagWD   = fw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] cond_exp;

    initial begin
        reset = 1'b1; StallE = 1'b0; FlushE = 1'b0; ALUFlagsE = 4'h0;
        MemtoRegD = 1'b0; ALUSrcD = 1'b0; ALUControlD = 2'b00;
        drive(4'hE, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11);
        tick(); tick();
        chk("rst_flags", Flags === 4'b0100);
        chk("rst_valid", ValidE === 1'b0);
        chk("rst_regw", RegWriteE === 1'b0);
        chk("rst_memw", MemWriteE === 1'b0);
        chk("rst_pcsrc", PCSrcE === 1'b0);
        chk("rst_condex", CondExE === 1'b0);
        chk("rst_execcnt", ExecCnt === 4'h0);
        reset = 1'b0;

        // CMP-like then BEQ
        drive(4'hE, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11);
        ALUControlD = 2'b01; ALUSrcD = 1'b1;
        tick();
        chk("cmp_valid", ValidE === 1'b1);
        chk("cmp_condex", CondExE === 1'b1);
        chk("cmp_regw", RegWriteE === 1'b0);
        chk("cmp_aluctl", ALUControlE === 2'b01);
        chk("cmp_alusrc", ALUSrcE === 1'b1);
        ALUFlagsE = 4'b0110;
        drive(4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        ALUControlD = 2'b00; ALUSrcD = 1'b0;
        tick();
        chk("cmp_flags", Flags === 4'b0110);
        chk("beq_pcsrc", PCSrcE === 1'b1);

        // N=1,V=0: GE fails, LT passes
        ALUFlagsE = 4'b1000;
        drive(4'hE, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
        tick();
        drive(4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        tick();
        chk("ge_flags", Flags === 4'b1000);
        chk("addge_regw", RegWriteE === 1'b0);
        ALUFlagsE = 4'b0000;
        drive(4'hB, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        tick();
        chk("addlt_regw", RegWriteE === 1'b1);
        chk("addlt_condex", CondExE === 1'b1);

        // STR held by a 3-cycle stall, then flushed
        drive(4'hE, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11);
        tick();
        chk("str_memw", MemWriteE === 1'b1);
        StallE = 1'b1; ALUFlagsE = 4'b0011;
        drive(4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_memw", MemWriteE === 1'b1);
            chk("stall_flags", Flags === 4'b1000);
        end
        StallE = 1'b0; FlushE = 1'b1;
        tick();
        chk("flush_valid", ValidE === 1'b0);
        chk("flush_memw", MemWriteE === 1'b0);
        chk("flush_commit_flags", Flags === 4'b0011);
        FlushE = 1'b0;

        // Flush together with stall: bubble loaded, flags untouched
        ALUFlagsE = 4'b1111;
        drive(4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11);
        tick();
        chk("pre_fs_valid", ValidE === 1'b1);
        chk("pre_fs_flags", Flags === 4'b0011);
        StallE = 1'b1; FlushE = 1'b1;
        tick();
        chk("fs_valid", ValidE === 1'b0);
        chk("fs_flags", Flags === 4'b0011);
        StallE = 1'b0; FlushE = 1'b0;

        // Clear flags, then update only N,Z; then reserved condition
        ALUFlagsE = 4'b0000;
        drive(4'hE, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
        tick();
        drive(4'hE, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
        tick();
        chk("clr_flags", Flags === 4'b0000);
        ALUFlagsE = 4'b1111;
        drive(4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        tick();
        chk("nz_flags", Flags === 4'b1100);
        chk("nv_valid", ValidE === 1'b1);
        chk("nv_condex", CondExE === 1'b0);
        chk("nv_pcsrc", PCSrcE === 1'b0);
        chk("nv_regw", RegWriteE === 1'b0);
        chk("nv_memw", MemWriteE === 1'b0);

        // All 16 conditions against N=1,Z=1,C=0,V=0
        ALUFlagsE = 4'b0000;
        cond_exp = 16'h6A99;
        for (int i = 0; i < 16; i++) begin
            drive(4'(i), 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
            tick();
            chk($sformatf("cond_%0h", i), CondExE === cond_exp[i]);
        end

        // Reset while a writing instruction sits in E
        drive(4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        tick();
        chk("mid_regw", RegWriteE === 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_regw", RegWriteE === 1'b0);
        chk("mid_rst_valid", ValidE === 1'b0);
        chk("mid_rst_flags", Flags === 4'b0100);
        tick();
        chk("mid_rst_regw2", RegWriteE === 1'b0);
        chk("mid_rst_exec", ExecCnt === 4'h0);
        chk("mid_rst_squash", SquashCnt === 4'h0);
        reset = 1'b0;

        // 20 executed instructions, then one squashed
        for (int i = 0; i < 20; i++) tick();
        drive(4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        tick(); tick();
`ifdef EXEC_PERF_CNT_EN
        chk("exec_sat", ExecCnt === 4'hF);
        chk("squash_cnt", SquashCnt === 4'h1);
`else
        chk("exec_off", ExecCnt === 4'h0);
        chk("squash_off", SquashCnt === 4'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
